// File: rtl/perf_counter_bank.sv
// Performance counter bank: cycle, retired-instruction and generic event counters
// with halt freeze, cycle-limit watchdog, snapshot registers and a registered readout.
module perf_counter_bank #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int SATURATE    = 1,
   parameter int CYCLE_LIMIT = 100000,
   parameter int SEL_W       = $clog2(NUM_CH + 2)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [NUM_CH-1:0]   evt,
   input  logic                retire,
   input  logic                halt,
   input  logic                clr,
   input  logic                snap,
   input  logic                rd_en,
   input  logic [SEL_W-1:0]    rd_sel,
   output logic [CNT_W-1:0]    rd_data,
   output logic                rd_valid,
   output logic [NUM_CH+1:0]   ovf,
   output logic                frozen,
   output logic                timeout
);

   localparam int NC = NUM_CH + 2;
   // A limit that cannot be represented in CNT_W bits can never be reached.
   localparam bit LIMIT_OK = (CYCLE_LIMIT > 0) && ($clog2(CYCLE_LIMIT + 1) <= CNT_W);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FROZEN  = 2'd1,
      TIMEOUT = 2'd2
   } stateT;

   stateT            stateReg;
   logic [CNT_W-1:0] cntReg  [NC];
   logic [CNT_W-1:0] cntNext [NC];
   logic [CNT_W-1:0] snapReg [NC];
   logic [NC-1:0]    incVec;
   logic [NC-1:0]    wrapHit;
   logic             counting;
   logic             limitHit;
   logic [CNT_W-1:0] rdMux;

   assign counting = en && (stateReg == RUN);
   assign incVec   = counting ? {evt, retire | halt, 1'b1} : '0;

   generate
      for (genvar gi = 0; gi < NC; gi++) begin : gCnt
         assign wrapHit[gi] = incVec[gi] && (&cntReg[gi]);
         assign cntNext[gi] = !incVec[gi]    ? cntReg[gi] :
                              (&cntReg[gi])  ? ((SATURATE != 0) ? cntReg[gi] : '0) :
                                               cntReg[gi] + CNT_W'(1);
      end
   endgenerate

   assign limitHit = LIMIT_OK && incVec[0] && (cntNext[0] == CNT_W'(CYCLE_LIMIT));

   always_comb begin
      rdMux = '0;
      for (int k = 0; k < NC; k++) begin
         if (rd_sel == SEL_W'(k)) rdMux = snapReg[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateReg <= RUN;
         for (int k = 0; k < NC; k++) begin
            cntReg[k]  <= '0;
            snapReg[k] <= '0;
         end
         ovf      <= '0;
         frozen   <= 1'b0;
         timeout  <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (clr) begin
            stateReg <= RUN;
            for (int k = 0; k < NC; k++) begin
               cntReg[k]  <= '0;
               snapReg[k] <= '0;
            end
            ovf     <= '0;
            frozen  <= 1'b0;
            timeout <= 1'b0;
         end else begin
            for (int k = 0; k < NC; k++) cntReg[k] <= cntNext[k];
            ovf <= ovf | wrapHit;
            // Halt takes priority over the watchdog; both capture the final increments.
            if (counting && halt) begin
               stateReg <= FROZEN;
               frozen   <= 1'b1;
               for (int k = 0; k < NC; k++) snapReg[k] <= cntNext[k];
            end else if (limitHit) begin
               stateReg <= TIMEOUT;
               timeout  <= 1'b1;
               for (int k = 0; k < NC; k++) snapReg[k] <= cntNext[k];
            end else if (snap) begin
               for (int k = 0; k < NC; k++) snapReg[k] <= cntReg[k];
            end
         end
         rd_valid <= rd_en;
         rd_data  <= rd_en ? rdMux : '0;
      end
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: three configurations share one stimulus stream and are
// compared every cycle against a behavioural model, plus directed constant checks.
module tb_perf_counter_bank;

   logic        clk = 1'b0;
   logic        rst_n, en, retire, halt, clr, snap, rd_en;
   logic [3:0]  evt;
   logic [2:0]  rd_sel;

   logic [31:0] rdA;
   logic [3:0]  rdB, rdC;
   logic        vA, vB, vC, frA, frB, frC, toA, toB, toC;
   logic [5:0]  ovfA, ovfB, ovfC;

   int nVec = 0;
   int nMis = 0;

   always #5 clk = ~clk;

   perf_counter_bank #(.NUM_CH(4), .CNT_W(32), .SATURATE(1), .CYCLE_LIMIT(50)) dutA (
      .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .retire(retire), .halt(halt),
      .clr(clr), .snap(snap), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rdA),
      .rd_valid(vA), .ovf(ovfA), .frozen(frA), .timeout(toA));

   perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .SATURATE(1), .CYCLE_LIMIT(0)) dutB (
      .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .retire(retire), .halt(halt),
      .clr(clr), .snap(snap), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rdB),
      .rd_valid(vB), .ovf(ovfB), .frozen(frB), .timeout(toB));

   perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .SATURATE(0), .CYCLE_LIMIT(0)) dutC (
      .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .retire(retire), .halt(halt),
      .clr(clr), .snap(snap), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rdC),
      .rd_valid(vC), .ovf(ovfC), .frozen(frC), .timeout(toC));

   // Reference model: one entry per configuration, states 0=run 1=frozen 2=timeout.
   int     cW   [3] = '{32, 4, 4};
   bit     cSat [3] = '{1'b1, 1'b1, 1'b0};
   longint cLim [3] = '{50, 0, 0};
   longint mCnt [3][6];
   longint mSnap[3][6];
   bit [5:0] mOvf[3];
   int     mSt  [3];
   longint mRd  [3];
   bit     mVal [3];

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMis++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelStep();
      for (int m = 0; m < 3; m++) begin
         longint maxV;
         longint old[6];
         bit [5:0] ev;
         maxV = (longint'(1) << cW[m]) - 1;
         ev   = {evt, retire | halt, 1'b1};
         if (!rst_n) begin
            for (int k = 0; k < 6; k++) begin
               mCnt[m][k] = 0;
               mSnap[m][k] = 0;
            end
            mOvf[m] = '0; mSt[m] = 0; mRd[m] = 0; mVal[m] = 1'b0;
         end else begin
            mVal[m] = rd_en;
            mRd[m]  = (rd_en && rd_sel < 6) ? mSnap[m][rd_sel] : 0;
            if (clr) begin
               for (int k = 0; k < 6; k++) begin
                  mCnt[m][k] = 0;
                  mSnap[m][k] = 0;
               end
               mOvf[m] = '0; mSt[m] = 0;
            end else if (en && mSt[m] == 0) begin
               for (int k = 0; k < 6; k++) old[k] = mCnt[m][k];
               for (int k = 0; k < 6; k++) begin
                  if (ev[k]) begin
                     if (mCnt[m][k] == maxV) begin
                        mOvf[m][k] = 1'b1;
                        if (!cSat[m]) mCnt[m][k] = 0;
                     end else begin
                        mCnt[m][k] = mCnt[m][k] + 1;
                     end
                  end
               end
               if (halt) begin
                  mSt[m] = 1;
                  for (int k = 0; k < 6; k++) mSnap[m][k] = mCnt[m][k];
               end else if (cLim[m] != 0 && mCnt[m][0] == cLim[m]) begin
                  mSt[m] = 2;
                  for (int k = 0; k < 6; k++) mSnap[m][k] = mCnt[m][k];
               end else if (snap) begin
                  for (int k = 0; k < 6; k++) mSnap[m][k] = old[k];
               end
            end else if (snap) begin
               for (int k = 0; k < 6; k++) mSnap[m][k] = mCnt[m][k];
            end
         end
      end
   endtask

   task automatic checkAll();
      chk("A.valid", vA, mVal[0]);
      if (mVal[0]) chk("A.data", rdA, mRd[0]);
      chk("A.ovf", ovfA, mOvf[0]);
      chk("A.frozen", frA, mSt[0] == 1);
      chk("A.timeout", toA, mSt[0] == 2);
      chk("B.valid", vB, mVal[1]);
      if (mVal[1]) chk("B.data", rdB, mRd[1]);
      chk("B.ovf", ovfB, mOvf[1]);
      chk("B.frozen", frB, mSt[1] == 1);
      chk("B.timeout", toB, mSt[1] == 2);
      chk("C.valid", vC, mVal[2]);
      if (mVal[2]) chk("C.data", rdC, mRd[2]);
      chk("C.ovf", ovfC, mOvf[2]);
      chk("C.frozen", frC, mSt[2] == 1);
      chk("C.timeout", toC, mSt[2] == 2);
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
      checkAll();
   endtask

   task automatic rdA_chk(logic [2:0] s, longint exp, string tag);
      rd_en = 1'b1; rd_sel = s;
      tick();
      chk(tag, rdA, exp);
      rd_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; evt = '0; retire = 1'b0; halt = 1'b0;
      clr = 1'b0; snap = 1'b0; rd_en = 1'b0; rd_sel = '0;

      // Reset state
      tick(); tick();
      chk("rst.ovf", ovfA, 0);
      chk("rst.frozen", frA, 0);
      chk("rst.timeout", toA, 0);
      chk("rst.valid", vA, 0);
      rst_n = 1'b1;

      // Basic counting
      en = 1'b1; evt = 4'b0101;
      for (int i = 0; i < 10; i++) begin
         retire = (i < 6);
         tick();
      end
      en = 1'b0; evt = '0; retire = 1'b0;
      snap = 1'b1; tick(); snap = 1'b0;
      rdA_chk(3'd0, 10, "basic.cycles");
      rdA_chk(3'd1, 6,  "basic.retired");
      rdA_chk(3'd2, 10, "basic.ch0");
      rdA_chk(3'd3, 0,  "basic.ch1");
      rdA_chk(3'd4, 10, "basic.ch2");
      rdA_chk(3'd5, 0,  "basic.ch3");
      chk("basic.ovf", ovfA, 0);

      // Halt freeze with auto snapshot
      clr = 1'b1; tick(); clr = 1'b0;
      en = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         retire = (i <= 6); halt = (i == 7);
         tick();
      end
      halt = 1'b0;
      chk("halt.frozen", frA, 1);
      evt = 4'b1111; retire = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      evt = '0; retire = 1'b0;
      rdA_chk(3'd0, 7, "halt.auto.cycles");
      rdA_chk(3'd1, 7, "halt.auto.retired");
      snap = 1'b1; tick(); snap = 1'b0;
      rdA_chk(3'd0, 7, "halt.live.cycles");
      rdA_chk(3'd1, 7, "halt.live.retired");
      rdA_chk(3'd2, 0, "halt.live.ch0");
      en = 1'b0;

      // Overflow: saturating and wrapping 4-bit counters
      clr = 1'b1; tick(); clr = 1'b0;
      en = 1'b1; evt = 4'b0001;
      for (int i = 0; i < 20; i++) tick();
      en = 1'b0; evt = '0;
      snap = 1'b1; tick(); snap = 1'b0;
      rd_en = 1'b1; rd_sel = 3'd2; tick(); rd_en = 1'b0;
      chk("ovf.A.ch0", rdA, 20);
      chk("ovf.sat.ch0", rdB, 15);
      chk("ovf.wrap.ch0", rdC, 4);
      chk("ovf.sat.flag", ovfB[2], 1);
      chk("ovf.wrap.flag", ovfC[2], 1);
      chk("ovf.A.flag", ovfA, 0);

      // Watchdog
      clr = 1'b1; tick(); clr = 1'b0;
      en = 1'b1;
      for (int i = 0; i < 49; i++) tick();
      chk("wd.before", toA, 0);
      tick();
      chk("wd.hit", toA, 1);
      chk("wd.notfrozen", frA, 0);
      evt = 4'b1111;
      for (int i = 0; i < 10; i++) tick();
      en = 1'b0; evt = '0;
      rdA_chk(3'd0, 50, "wd.snap.cycles");
      rdA_chk(3'd2, 0,  "wd.snap.ch0");
      clr = 1'b1; tick(); clr = 1'b0;
      chk("wd.clr", toA, 0);
      for (int s = 0; s < 6; s++) rdA_chk(3'(s), 0, "wd.clr.read");
      en = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      en = 1'b0;
      snap = 1'b1; tick(); snap = 1'b0;
      rdA_chk(3'd0, 3, "wd.resume");

      // clr versus same-cycle increment and snap; snap excludes same-cycle increment
      clr = 1'b1; snap = 1'b1; en = 1'b1; evt = 4'b0010; tick();
      clr = 1'b0; snap = 1'b0; en = 1'b0; evt = '0;
      rdA_chk(3'd3, 0, "clr.snap");
      snap = 1'b1; tick(); snap = 1'b0;
      rdA_chk(3'd3, 0, "clr.live");
      en = 1'b1; evt = 4'b0010;
      for (int i = 0; i < 3; i++) tick();
      snap = 1'b1; tick(); snap = 1'b0;
      en = 1'b0; evt = '0;
      rdA_chk(3'd3, 3, "snap.pre");
      snap = 1'b1; tick(); snap = 1'b0;
      rdA_chk(3'd3, 4, "snap.live");

      // Streaming readout and reset mid-stream
      tick();
      chk("rd.idle", vA, 0);
      rd_en = 1'b1; rd_sel = 3'd0; tick();
      chk("rd.v0", vA, 1); chk("rd.d0", rdA, 4);
      rd_sel = 3'd1; tick();
      chk("rd.v1", vA, 1); chk("rd.d1", rdA, 0);
      rd_sel = 3'd7; tick();
      chk("rd.v2", vA, 1); chk("rd.d2", rdA, 0);
      rd_en = 1'b0; tick();
      chk("rd.drop", vA, 0);
      rd_en = 1'b1; rd_sel = 3'd0; tick();
      chk("rd.pre.rst", vA, 1);
      rst_n = 1'b0; tick();
      chk("rst.mid.valid", vA, 0);
      chk("rst.mid.data", rdA, 0);
      chk("rst.mid.ovf", ovfA, 0);
      chk("rst.mid.frozen", frA, 0);
      chk("rst.mid.timeout", toA, 0);
      rst_n = 1'b1; rd_en = 1'b0;

      // Random stimulus against the model
      for (int i = 0; i < 800; i++) begin
         rst_n  = ($urandom_range(0, 199) != 0);
         en     = ($urandom_range(0, 7) != 0);
         evt    = 4'($urandom);
         retire = $urandom_range(0, 1) == 1;
         halt   = ($urandom_range(0, 39) == 0);
         clr    = ($urandom_range(0, 59) == 0);
         snap   = ($urandom_range(0, 7) == 0);
         rd_en  = $urandom_range(0, 1) == 1;
         rd_sel = 3'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
